score_bcd_counter: RTL and testbench
====================================

# score_bcd_counter

Parametrised BCD score accumulator for the Tetris score column. Game logic posts point bursts. The block queues them in a pending counter and drains it into an N-digit decimal score, one point per tick, so the score visibly counts up. Digit codes leave the block with leading-zero blanking applied, and the block keeps a high-score copy. Its digit outputs feed the per-cell digit glyph renderers in the VGA pixel path.

## Interface
- NUM_DIGITS, 8, number of decimal digits (1..16)
- ADD_WIDTH, 16, width of one point burst
- PEND_WIDTH, 21, width of pending-points counter (must be >= ADD_WIDTH)
- TICK_DIV, 1, clocks per counted point (>= 1)
- BLANK_CODE, 4'hF, code emitted for a blanked digit
- clk_25_175  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- add_valid  in  1  one-cycle strobe, add_points is valid
- add_points  in  ADD_WIDTH  points to queue; 0 is legal and a no-op
- clear  in  1  synchronous new-game clear
- hold  in  1  freeze counting (pause); adds are still accepted
- digits_out  out  4*NUM_DIGITS  score digits; digit i at [4i+3:4i], digit 0 least significant
- hi_digits_out  out  4*NUM_DIGITS  high score, same format
- busy  out  1  pending != 0
- saturated  out  1  score has reached all nines

## Operation
- State: score digits d[i] (4b BCD), hi digits h[i], pending (PEND_WIDTH), prescaler ($clog2(TICK_DIV), at least 1 bit), saturated flag.
- Queueing: on add_valid, pending <= pending + add_points.
  - The sum saturates at 2^PEND_WIDTH-1 and never wraps.
  - If a tick happens in the same cycle, the net effect is pending + add_points - 1, with the same saturation rule.
- Prescaler:
  - Runs only while pending != 0 and hold == 0.
  - tick = (prescaler == TICK_DIV-1). On tick, prescaler <= 0; otherwise prescaler increments.
  - When pending == 0, prescaler is forced to 0.
  - While hold is high, prescaler keeps its value.
- Tick (pending != 0, hold == 0, tick): pending decrements and score increments by 1 as a ripple BCD carry.
  - A digit at 9 becomes 0 and carries to the next digit.
  - If every digit is 9, the score holds at all nines and saturated <= 1. Pending still drains.
- Blanking: output digit i = BLANK_CODE when i > 0 and d[j] == 0 for all j >= i; otherwise d[i].
  - Digit 0 is always shown, so a zero score reads "0".
  - The same rule applies to hi_digits_out.
- clear:
  - If score > high score, h <= d. The comparison is unsigned decimal, digit-wise from the MSD.
  - Then d, pending, prescaler and saturated go to 0 in the same edge.
  - clear has priority over add_valid and tick in the same cycle; that add is dropped.
- High score is updated only on clear. It survives clear and is lost only on reset.

## Timing
- Reset values:
  - digits_out = {BLANK_CODE x (NUM_DIGITS-1), 4'h0}
  - hi_digits_out = same as digits_out
  - busy = 0
  - saturated = 0
- All outputs are driven from registers through combinational blanking and compare logic only. There is no input-to-output combinational path.
- Latency: add_valid sampled at edge k → busy = 1 after edge k.
  - First increment at edge k + TICK_DIV, then one increment every TICK_DIV edges.
  - busy falls after the edge that consumes the last point.
- hold asserted before edge n: no increment at edge n or later until hold drops. After release, counting resumes from the frozen prescaler value.
- reset asserted mid-drain: all state clears immediately (asynchronously). First valid add is accepted at the first edge after reset deasserts.

## Test plan
- Reset then idle: digits_out = 0xFFFFFFF0 (NUM_DIGITS=8), busy=0, saturated=0.
- TICK_DIV=1, add 3 at edge 0 → digit0 reads 1, 2, 3 after edges 1, 2, 3; busy falls after edge 3.
- Carry and blanking: preload to 99 via an add of 99, then add 1 → after draining, digits_out = 0xFFFFF100.
- TICK_DIV=4, add 2 → increments after edges 4 and 8 only. Hold high over edges 5-10 → second increment moves to edge 14.
- NUM_DIGITS=2, add 105 → score 99, saturated=1 after the 99th increment; busy stays high 6 more edges, then falls.
- Score 42 and hi 17, clear pulsed together with add_valid(5) → hi_digits_out = 0xFFFFFF42 (2-digit view: 42), digits_out = 0, busy = 0, and the add is dropped.

Source files
------------

// File: rtl/score_bcd_counter.sv
// +--------------------------------------------------------------------------+
// | score_bcd_counter: queued BCD score with high-score copy and blanking     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module score_bcd_counter #(
  parameter int         NUM_DIGITS = 8,
  parameter int         ADD_WIDTH  = 16,
  parameter int         PEND_WIDTH = 21,
  parameter int         TICK_DIV   = 1,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic                    clk_25_175,
  input  logic                    reset,
  input  logic                    add_valid,
  input  logic [ADD_WIDTH-1:0]    add_points,
  input  logic                    clear,
  input  logic                    hold,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [4*NUM_DIGITS-1:0] hi_digits_out,
  output logic                    busy,
  output logic                    saturated
);

  localparam int                  DW       = 4 * NUM_DIGITS;
  localparam int                  SW       = PEND_WIDTH + 1;
  localparam int                  PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  logic [DW-1:0]         score_q, score_d;
  logic [DW-1:0]         hi_q, hi_d;
  logic [PEND_WIDTH-1:0] pending_q, pending_d;
  logic [PS_W-1:0]       presc_q, presc_d;
  logic                  sat_q, sat_d;

  logic [DW-1:0]         score_inc;
  logic [SW-1:0]         pend_sum;
  logic                  pend_nz, tick, carry, inc_nines;

  // Leading zeros above digit 0 are replaced by the blank code.
  function automatic logic [DW-1:0] blank_digits(input logic [DW-1:0] d);
    logic lead;
    lead         = 1'b1;
    blank_digits = d;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead = lead & (d[4*i +: 4] == 4'd0);
      if (lead) blank_digits[4*i +: 4] = BLANK_CODE;
    end
  endfunction

  always_comb begin
    pend_nz   = (pending_q != '0);
    tick      = pend_nz && !hold && (presc_q == PS_LAST);

    // Ripple BCD increment; carry survives only if every digit was 9.
    score_inc = score_q;
    carry     = 1'b1;
    inc_nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
      if (score_inc[4*i +: 4] != 4'd9) inc_nines = 1'b0;
    end

    pend_sum = {1'b0, pending_q} + (add_valid ? SW'(add_points) : SW'(0)) - SW'(tick);

    score_d   = score_q;
    hi_d      = hi_q;
    pending_d = pending_q;
    presc_d   = presc_q;
    sat_d     = sat_q;

    if (clear) begin
      // Packed BCD orders the same as its decimal value.
      if (score_q > hi_q) hi_d = score_q;
      score_d   = '0;
      pending_d = '0;
      presc_d   = '0;
      sat_d     = 1'b0;
    end else begin
      pending_d = pend_sum[PEND_WIDTH] ? PEND_MAX : pend_sum[PEND_WIDTH-1:0];
      if (!pend_nz)      presc_d = '0;
      else if (hold)     presc_d = presc_q;
      else if (tick)     presc_d = '0;
      else               presc_d = presc_q + PS_W'(1);
      if (tick) begin
        if (!carry) score_d = score_inc;
        sat_d = sat_q | carry | inc_nines;
      end
    end
  end

  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      score_q   <= '0;
      hi_q      <= '0;
      pending_q <= '0;
      presc_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      score_q   <= score_d;
      hi_q      <= hi_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      sat_q     <= sat_d;
    end
  end

  assign digits_out    = blank_digits(score_q);
  assign hi_digits_out = blank_digits(hi_q);
  assign busy          = (pending_q != '0);
  assign saturated     = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_score_bcd_counter.sv
// +--------------------------------------------------------------------------+
// | tb_score_bcd_counter: directed checks on three parameterisations         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_score_bcd_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // a: 8 digits, TICK_DIV=1; b: 8 digits, TICK_DIV=4; c: 2 digits, 8-bit pending
  logic        rst_a, rst_b, rst_c;
  logic        av_a, av_b, av_c;
  logic [15:0] ap_a, ap_b;
  logic [7:0]  ap_c;
  logic        clr_a, clr_b, clr_c;
  logic        hold_a, hold_b, hold_c;
  logic [31:0] dig_a, hi_a, dig_b, hi_b;
  logic [7:0]  dig_c, hi_c;
  logic        busy_a, busy_b, busy_c, sat_a, sat_b, sat_c;

  score_bcd_counter #(.NUM_DIGITS(8), .ADD_WIDTH(16), .PEND_WIDTH(21), .TICK_DIV(1), .BLANK_CODE(4'hF)) dut_a (
    .clk_25_175(clk), .reset(rst_a), .add_valid(av_a), .add_points(ap_a), .clear(clr_a),
    .hold(hold_a), .digits_out(dig_a), .hi_digits_out(hi_a), .busy(busy_a), .saturated(sat_a));

  score_bcd_counter #(.NUM_DIGITS(8), .ADD_WIDTH(16), .PEND_WIDTH(21), .TICK_DIV(4), .BLANK_CODE(4'hF)) dut_b (
    .clk_25_175(clk), .reset(rst_b), .add_valid(av_b), .add_points(ap_b), .clear(clr_b),
    .hold(hold_b), .digits_out(dig_b), .hi_digits_out(hi_b), .busy(busy_b), .saturated(sat_b));

  score_bcd_counter #(.NUM_DIGITS(2), .ADD_WIDTH(8), .PEND_WIDTH(8), .TICK_DIV(1), .BLANK_CODE(4'hF)) dut_c (
    .clk_25_175(clk), .reset(rst_c), .add_valid(av_c), .add_points(ap_c), .clear(clr_c),
    .hold(hold_c), .digits_out(dig_c), .hi_digits_out(hi_c), .busy(busy_c), .saturated(sat_c));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_add(input int which, input logic v, input logic [15:0] pts);
    case (which)
      0:       begin av_a = v; ap_a = pts; end
      1:       begin av_b = v; ap_b = pts; end
      default: begin av_c = v; ap_c = pts[7:0]; end
    endcase
  endtask

  task automatic set_clr(input int which, input logic v);
    case (which)
      0:       clr_a = v;
      1:       clr_b = v;
      default: clr_c = v;
    endcase
  endtask

  // Returns at the negedge following the edge that sampled the add.
  task automatic post(input int which, input logic [15:0] pts);
    @(negedge clk);
    set_add(which, 1'b1, pts);
    step();
    set_add(which, 1'b0, 16'd0);
  endtask

  task automatic pulse_clear(input int which);
    @(negedge clk);
    set_clr(which, 1'b1);
    step();
    set_clr(which, 1'b0);
  endtask

  function automatic logic busy_of(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic wait_idle(input int which, input int max_cyc);
    int n = 0;
    while (busy_of(which) && n < max_cyc) begin
      step();
      n++;
    end
    if (busy_of(which)) check_eq("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    {av_a, av_b, av_c, clr_a, clr_b, clr_c, hold_a, hold_b, hold_c} = '0;
    ap_a = '0; ap_b = '0; ap_c = '0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #22;
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    step();

    // Reset state
    check_eq("a_rst_digits", dig_a, 64'hFFFFFFF0);
    check_eq("a_rst_hi", hi_a, 64'hFFFFFFF0);
    check_eq("a_rst_busy", busy_a, 64'd0);
    check_eq("a_rst_sat", sat_a, 64'd0);
    check_eq("c_rst_digits", dig_c, 64'hF0);
    check_eq("c_rst_hi", hi_c, 64'hF0);

    // ---------------- dut_a: TICK_DIV=1 ----------------
    post(0, 16'd0);
    check_eq("a_add0_busy", busy_a, 64'd0);
    check_eq("a_add0_digits", dig_a, 64'hFFFFFFF0);

    post(0, 16'd3);
    check_eq("a_e0_busy", busy_a, 64'd1);
    check_eq("a_e0_digits", dig_a, 64'hFFFFFFF0);
    step(); check_eq("a_e1_digits", dig_a, 64'hFFFFFFF1);
    step(); check_eq("a_e2_digits", dig_a, 64'hFFFFFFF2);
    check_eq("a_e2_busy", busy_a, 64'd1);
    step(); check_eq("a_e3_digits", dig_a, 64'hFFFFFFF3);
    check_eq("a_e3_busy", busy_a, 64'd0);

    post(0, 16'd96);
    wait_idle(0, 200);
    check_eq("a_99", dig_a, 64'hFFFFFF99);
    post(0, 16'd1);
    wait_idle(0, 20);
    check_eq("a_100_blank", dig_a, 64'hFFFFF100);

    // Add arriving in the same cycle as a tick
    @(negedge clk);
    set_add(0, 1'b1, 16'd2);
    step();
    set_add(0, 1'b1, 16'd3);
    step();
    set_add(0, 1'b0, 16'd0);
    check_eq("a_ovl_e1", dig_a, 64'hFFFFF101);
    step(); step(); step();
    check_eq("a_ovl_e4_busy", busy_a, 64'd1);
    check_eq("a_ovl_e4", dig_a, 64'hFFFFF104);
    step();
    check_eq("a_ovl_e5_busy", busy_a, 64'd0);
    check_eq("a_ovl_e5", dig_a, 64'hFFFFF105);

    // Asynchronous reset mid-drain
    post(0, 16'd50);
    repeat (5) step();
    #2 rst_a = 1'b1;
    #1;
    check_eq("a_arst_digits", dig_a, 64'hFFFFFFF0);
    check_eq("a_arst_busy", busy_a, 64'd0);
    check_eq("a_arst_hi", hi_a, 64'hFFFFFFF0);
    @(negedge clk);
    rst_a = 1'b0;

    // High score via clear
    post(0, 16'd17);
    wait_idle(0, 40);
    pulse_clear(0);
    check_eq("a_hi17", hi_a, 64'hFFFFFF17);
    check_eq("a_clr_digits", dig_a, 64'hFFFFFFF0);

    post(0, 16'd42);
    wait_idle(0, 60);
    check_eq("a_42", dig_a, 64'hFFFFFF42);
    @(negedge clk);
    clr_a = 1'b1;
    set_add(0, 1'b1, 16'd5);
    step();
    clr_a = 1'b0;
    set_add(0, 1'b0, 16'd0);
    check_eq("a_hi42", hi_a, 64'hFFFFFF42);
    check_eq("a_clr2_digits", dig_a, 64'hFFFFFFF0);
    check_eq("a_clr2_busy", busy_a, 64'd0);
    step();
    check_eq("a_clr2_drop", dig_a, 64'hFFFFFFF0);

    post(0, 16'd7);
    wait_idle(0, 20);
    pulse_clear(0);
    check_eq("a_hi_kept", hi_a, 64'hFFFFFF42);

    // ---------------- dut_b: TICK_DIV=4 ----------------
    post(1, 16'd2);
    step(); step(); step();
    check_eq("b_e3", dig_b, 64'hFFFFFFF0);
    step(); check_eq("b_e4", dig_b, 64'hFFFFFFF1);
    step(); step(); step();
    check_eq("b_e7", dig_b, 64'hFFFFFFF1);
    step(); check_eq("b_e8", dig_b, 64'hFFFFFFF2);
    check_eq("b_e8_busy", busy_b, 64'd0);

    post(1, 16'd2);
    step(); step(); step(); step();
    check_eq("b_h_e4", dig_b, 64'hFFFFFFF3);
    hold_b = 1'b1;
    repeat (6) step();
    check_eq("b_h_e10", dig_b, 64'hFFFFFFF3);
    check_eq("b_h_e10_busy", busy_b, 64'd1);
    hold_b = 1'b0;
    step(); step(); step();
    check_eq("b_h_e13", dig_b, 64'hFFFFFFF3);
    step();
    check_eq("b_h_e14", dig_b, 64'hFFFFFFF4);
    check_eq("b_h_e14_busy", busy_b, 64'd0);

    // ---------------- dut_c: 2 digits, saturation ----------------
    post(2, 16'd105);
    repeat (98) step();
    check_eq("c_e98", dig_c, 64'h98);
    check_eq("c_e98_sat", sat_c, 64'd0);
    step();
    check_eq("c_e99", dig_c, 64'h99);
    check_eq("c_e99_sat", sat_c, 64'd1);
    repeat (5) step();
    check_eq("c_e104_busy", busy_c, 64'd1);
    step();
    check_eq("c_e105_busy", busy_c, 64'd0);
    check_eq("c_e105", dig_c, 64'h99);

    pulse_clear(2);
    check_eq("c_hi99", hi_c, 64'h99);
    check_eq("c_clr_digits", dig_c, 64'hF0);
    check_eq("c_clr_sat", sat_c, 64'd0);

    // Pending counter saturates at 255 instead of wrapping
    @(negedge clk);
    set_add(2, 1'b1, 16'd200);
    step();
    set_add(2, 1'b1, 16'd200);
    step();
    set_add(2, 1'b0, 16'd0);
    repeat (254) step();
    check_eq("c_psat_e255_busy", busy_c, 64'd1);
    step();
    check_eq("c_psat_e256_busy", busy_c, 64'd0);
    check_eq("c_psat_sat", sat_c, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
